dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RV32I core. It is the far end of the decoder's store/load controls (ram_we, ram_w_op, mem_ext_op).
- Accepts one load/store request per valid/ready handshake, stalls for a programmable latency, then commits byte-lane stores or returns sign/zero-extended loads.
- Flags misaligned, out-of-range and bad-encoding accesses as an error response that feeds the exception unit.
- Sits at the MEM stage; the MEM stage stalls while req_ready or resp_valid is low.

Parameters:
- ADDR_WIDTH, 10, word-index bits; storage depth = 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, WAIT cycles before the array access; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_w_op  in  2  store width: 00 = B, 01 = H, 10 = W, 11 = illegal
- req_ext_op  in  3  load extension: 000 = B, 001 = BU, 010 = H, 011 = HU, 100 = W, others illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  1 = access fault (misaligned, out of range or illegal op)

Behaviour:
- Reset (rst_n low at a rising edge): state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
  - Array contents are not reset.
  - Reset mid-operation abandons the request. A store still in WAIT is never committed.
- FSM states: IDLE, WAIT, RESP. req_ready = 1 only in IDLE.
- IDLE: on an edge with req_valid & req_ready, latch we, w_op, ext_op, addr and wdata. Then evaluate the fault condition.
- Fault condition (any of):
  - addr[31:ADDR_WIDTH+2] != 0
  - halfword access with addr[0] = 1
  - word access with addr[1:0] != 0
  - store with w_op = 11
  - load with ext_op > 100
- Fault path: go directly to RESP with resp_err = 1 and resp_rdata = 0. No array write occurs.
- No-fault path: go to WAIT and load the counter with LATENCY-1.
- WAIT: decrement the counter each cycle. At the edge where the counter = 0, perform the array access and go to RESP with resp_err = 0.
  - resp_valid is high starting LATENCY+1 cycles after the accept edge.
  - Faults show resp_valid one cycle after the accept edge.
- Store: word index = addr[ADDR_WIDTH+1:2], lane = addr[1:0]. Only the written bytes change.
  - B: wdata[7:0] goes into byte lane `lane`.
  - H: wdata[15:0] goes into lanes {addr[1],0} and {addr[1],1}.
  - W: all four lanes are written.
  - resp_rdata = 0.
- Load: read the word at the index, extract the field and register it into resp_rdata.
  - B/BU: byte at lane addr[1:0].
  - H/HU: half at addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_valid & resp_ready at an edge. At that edge, go to IDLE and clear resp_valid, resp_rdata and resp_err.
  - The earliest next accept is the cycle after the response handshake, so the peak rate is one request per LATENCY+2 cycles.
  - If resp_ready is held high in RESP, the handshake occurs on the first edge after entry.
- Request inputs are ignored outside IDLE; req_valid may stay high without side effects.
- The req_we = 0 path ignores w_op; the req_we = 1 path ignores ext_op.
- Only the latched request values are used after accept, so changes on req_* during WAIT have no effect.

Test Plan:
1. Reset: hold rst_n = 0 for 2 cycles with req_valid = 1 -> req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0. No array change.
2. Byte lanes, LATENCY = 2:
   - SW 0x8899AABB @0x10, then SB 0x5A @0x12, then LB @0x12 -> rdata 0x0000005A.
   - LW @0x10 -> 0x885AAABB.
   - The LW resp_valid appears exactly 3 cycles after its accept edge.
3. Extension:
   - Word 0x80F1FF7E at 0x20.
   - LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080.
   - LH @0x22 -> 0xFFFF80F1; LHU @0x20 -> 0x0000FF7E.
4. Faults:
   - LW @0x22, SH @0x21 and LB @0x00001000 (ADDR_WIDTH = 10) -> resp_err = 1, rdata = 0, resp_valid 1 cycle after accept.
   - A following LW @0x20 shows the memory unchanged.
   - Store with w_op = 11 and load with ext_op = 101 -> resp_err = 1.
5. Backpressure: hold resp_ready = 0 for 5 cycles in RESP -> outputs held constant and req_ready = 0 with req_valid = 1. Raise resp_ready -> IDLE next cycle.
6. Reset mid-WAIT: accept SW 0xDEADBEEF @0x30, assert rst_n = 0 in the first WAIT cycle -> later LW @0x30 returns the prior contents and resp_valid never fires for the aborted store.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake, programmable wait,
// byte-lane stores, sign/zero-extended loads and fault reporting.

module dmem_lane #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  logic [7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_w_op,
  input  logic [2:0]  req_ext_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int         NUM_LANES = 4;
  localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [1:0]            w_op;
    logic [2:0]            ext_op;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            off;
    logic [31:0]           wdata;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;
  logic [3:0] cnt;
  logic       req_fault;
  logic       access;

  logic [NUM_LANES-1:0]       lane_be;
  logic [NUM_LANES-1:0]       lane_we;
  logic [NUM_LANES-1:0][7:0]  lane_wd;
  logic [NUM_LANES-1:0][7:0]  lane_rd;
  logic [7:0]                 rbyte;
  logic [15:0]                rhalf;
  logic [31:0]                load_val;

  // Fault check on the live request; only used on the accept edge.
  always_comb begin
    req_fault = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    if (req_we) begin
      case (req_w_op)
        2'b01:   if (req_addr[0])    req_fault = 1'b1;
        2'b10:   if (|req_addr[1:0]) req_fault = 1'b1;
        2'b11:   req_fault = 1'b1;
        default: ;
      endcase
    end else begin
      case (req_ext_op)
        3'b000, 3'b001: ;
        3'b010, 3'b011: if (req_addr[0])    req_fault = 1'b1;
        3'b100:         if (|req_addr[1:0]) req_fault = 1'b1;
        default:        req_fault = 1'b1;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid)       state_nxt = req_fault ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0)     state_nxt = S_RESP;
      S_RESP: if (resp_ready)      state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
  end

  assign access = (state == S_WAIT) && (cnt == 4'd0);

  // Lane enables and lane-aligned store data
  always_comb begin
    lane_be = '0;
    lane_wd = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      case (req_q.w_op)
        2'b00: begin
          lane_be[l] = (req_q.off == 2'(l));
          lane_wd[l] = req_q.wdata[7:0];
        end
        2'b01: begin
          lane_be[l] = (req_q.off[1] == l[1]);
          lane_wd[l] = l[0] ? req_q.wdata[15:8] : req_q.wdata[7:0];
        end
        2'b10: begin
          lane_be[l] = 1'b1;
          lane_wd[l] = req_q.wdata[8*l +: 8];
        end
        default: ;
      endcase
    end
  end

  // Reset gating keeps an abandoned store from landing on the reset edge.
  assign lane_we = lane_be & {NUM_LANES{access & req_q.we & rst_n}};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dmem_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk   (clk),
      .we    (lane_we[l]),
      .idx   (req_q.idx),
      .wdata (lane_wd[l]),
      .rdata (lane_rd[l])
    );
  end

  // Load extraction
  always_comb begin
    rbyte = lane_rd[req_q.off];
    rhalf = req_q.off[1] ? {lane_rd[3], lane_rd[2]} : {lane_rd[1], lane_rd[0]};
    case (req_q.ext_op)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_val = {24'd0, rbyte};
      3'b010:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b011:  load_val = {16'd0, rhalf};
      3'b100:  load_val = lane_rd;
      default: load_val = 32'd0;
    endcase
  end

  // Request latch, wait counter and registered response payload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q      <= '0;
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          req_q.we     <= req_we;
          req_q.w_op   <= req_w_op;
          req_q.ext_op <= req_ext_op;
          req_q.idx    <= req_addr[ADDR_WIDTH+1:2];
          req_q.off    <= req_addr[1:0];
          req_q.wdata  <= req_wdata;
          if (req_fault) begin
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            cnt <= LAT_M1;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            resp_err   <= 1'b0;
            resp_rdata <= req_q.we ? 32'd0 : load_val;
          end
        end
        S_RESP: if (resp_ready) begin
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder (ADDR_WIDTH=10, LATENCY=2).

module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_w_op;
  logic [2:0]  req_ext_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_w_op   (req_w_op),
    .req_ext_op (req_ext_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  w_op;
    logic [2:0]  ext_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] wop, input logic [2:0] ext,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] erd, input logic eer, input int elat);
    vec_t v;
    v.we = we; v.w_op = wop; v.ext_op = ext; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = erd; v.exp_err = eer; v.exp_lat = elat;
    vq.push_back(v);
  endtask

  // Issue one request, count negedges from accept to resp_valid, then handshake.
  task automatic do_req(input logic we, input logic [1:0] wop, input logic [2:0] ext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_w_op = wop; req_ext_op = ext;
    req_addr = addr; req_wdata = wdata; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // scribble the request bus; only latched values may matter
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5555_AAAA; req_we = ~we;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) lat = -1;
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, hold_rd;
    logic        er, seen;
    int          lat;

    // 1. reset with a request pending on the bus
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_w_op = 2'b10; req_ext_op = 3'b100;
    req_addr = 32'h30; req_wdata = 32'hBAD0_BAD0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata,      32'd0);
    chk("rst_resp_err",   32'(resp_err),   32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;

    //    we  wop    ext     addr          wdata          exp_rdata     err lat
    add(1, 2'b10, 3'b000, 32'h10,       32'h8899AABB, 32'h0,        0, 3); // SW
    add(1, 2'b00, 3'b000, 32'h12,       32'h0000005A, 32'h0,        0, 3); // SB
    add(0, 2'b00, 3'b000, 32'h12,       32'h0,        32'h0000005A, 0, 3); // LB
    add(0, 2'b00, 3'b100, 32'h10,       32'h0,        32'h885AAABB, 0, 3); // LW
    add(1, 2'b10, 3'b000, 32'h20,       32'h80F1FF7E, 32'h0,        0, 3); // SW
    add(0, 2'b00, 3'b000, 32'h23,       32'h0,        32'hFFFFFF80, 0, 3); // LB
    add(0, 2'b00, 3'b001, 32'h23,       32'h0,        32'h00000080, 0, 3); // LBU
    add(0, 2'b00, 3'b010, 32'h22,       32'h0,        32'hFFFF80F1, 0, 3); // LH
    add(0, 2'b00, 3'b011, 32'h20,       32'h0,        32'h0000FF7E, 0, 3); // LHU
    add(0, 2'b00, 3'b100, 32'h22,       32'h0,        32'h0,        1, 1); // LW misaligned
    add(1, 2'b01, 3'b000, 32'h21,       32'h00001234, 32'h0,        1, 1); // SH misaligned
    add(0, 2'b00, 3'b000, 32'h00001000, 32'h0,        32'h0,        1, 1); // LB out of range
    add(0, 2'b00, 3'b100, 32'h20,       32'h0,        32'h80F1FF7E, 0, 3); // LW unchanged
    add(1, 2'b10, 3'b000, 32'h40,       32'h11223344, 32'h0,        0, 3); // SW
    add(1, 2'b11, 3'b000, 32'h40,       32'hFFFFFFFF, 32'h0,        1, 1); // store w_op=11
    add(0, 2'b00, 3'b101, 32'h40,       32'h0,        32'h0,        1, 1); // load ext_op=101
    add(1, 2'b01, 3'b000, 32'h42,       32'h0000CAFE, 32'h0,        0, 3); // SH upper
    add(1, 2'b00, 3'b111, 32'h41,       32'h00000077, 32'h0,        0, 3); // SB, ext ignored
    add(0, 2'b11, 3'b100, 32'h40,       32'h0,        32'hCAFE7744, 0, 3); // LW, w_op ignored
    add(0, 2'b00, 3'b010, 32'h42,       32'h0,        32'hFFFFCAFE, 0, 3); // LH
    add(1, 2'b10, 3'b000, 32'h30,       32'h01020304, 32'h0,        0, 3); // SW for reset test

    foreach (vq[i]) begin
      do_req(vq[i].we, vq[i].w_op, vq[i].ext_op, vq[i].addr, vq[i].wdata, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, vq[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vq[i].exp_err));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vq[i].exp_lat));
      chk($sformatf("v%0d_idle", i), {30'd0, req_ready, resp_valid}, 32'd2);
    end

    // 5. backpressure: hold the LW response for 5 cycles with req_valid high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_w_op = 2'b00; req_ext_op = 3'b100;
    req_addr = 32'h10; req_wdata = 32'h0; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h20;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd3);
    hold_rd = 32'h885AAABB;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(resp_valid), 32'd1);
      chk($sformatf("bp_rdata%0d", k), resp_rdata, hold_rd);
      chk($sformatf("bp_err%0d", k), 32'(resp_err), 32'd0);
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_release", {30'd0, req_ready, resp_valid}, 32'd2);
    chk("bp_clr_rdata", resp_rdata, 32'd0);

    // 6. reset in the first WAIT cycle abandons the store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_w_op = 2'b10; req_ext_op = 3'b000;
    req_addr = 32'h30; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mw_in_wait", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("mw_no_resp", 32'(seen), 32'd0);
    chk("mw_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 2'b00, 3'b100, 32'h30, 32'h0, rd, er, lat);
    chk("mw_lw_rdata", rd, 32'h01020304);
    chk("mw_lw_err", 32'(er), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
